tone_scheduler: RTL and testbench
=================================

Name: tone_scheduler

Overview:
Sequences and shares the single audio tone clock divider between two requesters: channel 0 is UI key-click/beep and channel 1 is alarm/notification melody. Each request carries a frequency and a duration in milliseconds. The block drives the divider's enable and frequency inputs for exactly that duration, inserts a configurable silent gap, then reports completion. Sits between the UI/alarm logic and the divider feeding the speaker/PWM path.

Parameters:
CLOCK_FREQ, 50_000_000, system clock frequency in Hz; one ms tick = CLOCK_FREQ/1000 cycles (integer division).
WIDTH, 32, width of frequency fields; matches the divider's freq_hertz input.
DUR_WIDTH, 16, width of duration fields in ms.
GAP_MS, 1, silent gap after each tone in ms; 0 = no gap.

Ports:
clk  in  1  system clock, all logic on rising edge.
reset  in  1  asynchronous, active-high; clears all state.
req0_valid  in  1  channel 0 request pending.
req0_freq  in  WIDTH  channel 0 tone frequency, Hz; 0 = rest.
req0_dur_ms  in  DUR_WIDTH  channel 0 duration, ms.
req0_ready  out  1  channel 0 request accepted this cycle (valid & ready).
req1_valid, req1_freq, req1_dur_ms, req1_ready  same as channel 0, for channel 1.
abort  in  1  terminate the current tone/gap immediately.
div_enable  out  1  to divider enable.
div_freq_hertz  out  WIDTH  to divider freq_hertz.
busy  out  1  high in any state other than IDLE.
active_src  out  1  source of the current/last-accepted request.
done  out  1  one-cycle pulse when a request completes normally.
done_src  out  1  source of the completed request, valid while done=1.

Behaviour:
- Reset: state=IDLE, div_enable=0, div_freq_hertz=0, busy=0, active_src=0, done=0, done_src=0, tick and ms counters=0, last_grant=1 (so channel 0 wins first contention).
- States: IDLE, PLAY, GAP.
- Ready is combinational. reqN_ready=1 only when state=IDLE, abort=0, reqN_valid=1 and the channel is granted.
- Arbitration: one valid channel is granted. When both are valid, the channel != last_grant is granted (round-robin). last_grant updates on acceptance. At most one ready per cycle.
- Accept at cycle T: freq, dur and src are latched. At T+1: state=PLAY, busy=1, active_src=src, div_freq_hertz=freq, div_enable=(freq!=0), tick/ms counters=0.
- dur_ms=0: at T+1 go directly to the gap handling (GAP if GAP_MS>0, else IDLE with done). div_enable stays 0.
- PLAY: the tick counter counts 0..CLOCK_FREQ/1000-1. The ms counter increments on wrap. PLAY lasts exactly dur_ms*(CLOCK_FREQ/1000) cycles.
- Leaving PLAY: div_enable=0 from the first cycle after PLAY. div_freq_hertz holds its value. Next state is GAP (counters cleared) if GAP_MS>0, else IDLE.
- GAP: div_enable=0 for exactly GAP_MS*(CLOCK_FREQ/1000) cycles, then IDLE.
- Normal completion: done=1 and done_src=src in the first IDLE cycle. A new request may be accepted in that same cycle.
- abort=1 in PLAY or GAP: next cycle state=IDLE, div_enable=0, busy=0, no done. abort in IDLE blocks acceptance that cycle.
- Request inputs are ignored outside IDLE. Changes on reqN_freq or reqN_dur_ms during PLAY have no effect.
- Counters are wide enough for DUR_WIDTH ms without wrap. Max dur (2^DUR_WIDTH-1) must be timed exactly.
- Asynchronous reset mid-PLAY: outputs return to reset values immediately, without waiting for a clock edge.

Test Plan (CLOCK_FREQ=10_000, tick = 10 cycles, GAP_MS=1):
- Single tone: req0 freq=440, dur=3, accepted cycle T -> div_enable high T+1..T+30, freq=440; low T+31..T+40; done=1, done_src=0 at T+41.
- Contention: req0 and req1 both held valid -> grants alternate 0,1,0,1. Each done_src matches its grant. No overlap of div_enable periods.
- Rest and zero-duration: freq=0, dur=2 -> div_enable stays 0 for 20+10 cycles, then done. dur=0 -> GAP 10 cycles, then done. With GAP_MS=0 -> done at T+1.
- Abort: abort at PLAY cycle 12 -> div_enable=0 and busy=0 the next cycle. No done pulse. A pending req1 is accepted the cycle after.
- Back-to-back: req1_valid held high through done -> accepted in the done cycle. PLAY restarts the following cycle.
- Reset: assert reset asynchronously mid-PLAY -> div_enable, busy and done drop to 0 without a clock edge. After release, the first contention grants channel 0.

Source files
------------

// File: rtl/tone_scheduler.sv
// -----------------------------------------------------------------------------
// tone_scheduler
//
// Shares the single audio tone-clock divider between two requesters
// (channel 0: UI key-click/beep, channel 1: alarm/notification melody).
// An accepted request drives the divider for dur_ms milliseconds. A silent
// gap of GAP_MS milliseconds follows, and then completion is reported.
//
// Ports
//   clk             system clock, rising edge
//   reset           asynchronous, active-high, clears all state
//   reqN_valid      channel N request pending
//   reqN_freq       channel N tone frequency in Hz (0 = rest)
//   reqN_dur_ms     channel N tone duration in ms
//   reqN_ready      channel N request accepted this cycle (combinational)
//   abort           terminate current tone/gap; blocks acceptance in IDLE
//   div_enable      divider enable
//   div_freq_hertz  divider frequency
//   busy            high in any state other than IDLE
//   active_src      source of the current/last-accepted request
//   done            one-cycle pulse on normal completion
//   done_src        source of the completed request, valid while done=1
// -----------------------------------------------------------------------------
module tone_scheduler #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int WIDTH      = 32,
    parameter int DUR_WIDTH  = 16,
    parameter int GAP_MS     = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    input  logic [WIDTH-1:0]     req0_freq,
    input  logic [DUR_WIDTH-1:0] req0_dur_ms,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [WIDTH-1:0]     req1_freq,
    input  logic [DUR_WIDTH-1:0] req1_dur_ms,
    output logic                 req1_ready,
    input  logic                 abort,
    output logic                 div_enable,
    output logic [WIDTH-1:0]     div_freq_hertz,
    output logic                 busy,
    output logic                 active_src,
    output logic                 done,
    output logic                 done_src
);

    // One ms tick; guarded so very slow clocks still give a 1-cycle tick.
    localparam int TICKS = (CLOCK_FREQ / 1000 > 0) ? (CLOCK_FREQ / 1000) : 1;
    localparam int TW    = (TICKS > 1) ? $clog2(TICKS) : 1;
    // The ms counter must hold both dur-1 and GAP_MS-1.
    localparam int GW    = (GAP_MS > 1) ? $clog2(GAP_MS) : 1;
    localparam int MS_W  = (DUR_WIDTH > GW) ? DUR_WIDTH : GW;

    localparam logic [TW-1:0]   TICK_LAST = TW'(TICKS - 1);
    localparam logic [MS_W-1:0] GAP_LAST  = MS_W'((GAP_MS > 0) ? (GAP_MS - 1) : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  freq_q, freq_d;
    logic [MS_W-1:0]   dur_q, dur_d;
    logic              src_q, src_d;
    logic              last_grant_q, last_grant_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [MS_W-1:0]   ms_q, ms_d;
    logic              done_q, done_d;

    logic              grant;
    logic              accept;
    logic              tick_end;
    logic [WIDTH-1:0]  sel_freq;
    logic [MS_W-1:0]   sel_dur;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            freq_q       <= '0;
            dur_q        <= '0;
            src_q        <= 1'b0;
            last_grant_q <= 1'b1;   // channel 0 wins the first contention
            tick_q       <= '0;
            ms_q         <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            freq_q       <= freq_d;
            dur_q        <= dur_d;
            src_q        <= src_d;
            last_grant_q <= last_grant_d;
            tick_q       <= tick_d;
            ms_q         <= ms_d;
            done_q       <= done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        freq_d       = freq_q;
        dur_d        = dur_q;
        src_d        = src_q;
        last_grant_d = last_grant_q;
        tick_d       = tick_q;
        ms_d         = ms_q;
        done_d       = 1'b0;

        tick_end = (tick_q == TICK_LAST);
        sel_freq = grant ? req1_freq : req0_freq;
        sel_dur  = MS_W'(grant ? req1_dur_ms : req0_dur_ms);

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    freq_d       = sel_freq;
                    dur_d        = sel_dur;
                    src_d        = grant;
                    last_grant_d = grant;
                    tick_d       = '0;
                    ms_d         = '0;
                    if (sel_dur == '0) begin
                        // Zero-length tone skips straight to the gap (or completes).
                        if (GAP_MS > 0) begin
                            state_d = GAP;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        state_d = PLAY;
                    end
                end
            end

            PLAY: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (tick_end) begin
                    tick_d = '0;
                    if (ms_q == dur_q - MS_W'(1)) begin
                        ms_d = '0;
                        if (GAP_MS > 0) begin
                            state_d = GAP;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        ms_d = ms_q + MS_W'(1);
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end

            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (tick_end) begin
                    tick_d = '0;
                    if (ms_q == GAP_LAST) begin
                        ms_d    = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        ms_d = ms_q + MS_W'(1);
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs: arbitration/ready plus decode of the registered state.
    // Everything visible to the divider derives from registers cleared by the
    // asynchronous reset, so reset silences the speaker without a clock edge.
    // -------------------------------------------------------------------------
    always_comb begin
        // Round-robin: on contention the channel not granted last time wins.
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = req1_valid;
        end

        accept     = (state_q == IDLE) && !abort && (req0_valid || req1_valid);
        req0_ready = accept && !grant;
        req1_ready = accept && grant;

        busy           = (state_q != IDLE);
        div_enable     = (state_q == PLAY) && (freq_q != '0);
        div_freq_hertz = freq_q;
        active_src     = src_q;
        done           = done_q;
        done_src       = src_q;
    end

endmodule

// File: tb/tb_tone_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tone_scheduler: directed bench for tone_scheduler with a 10-cycle ms
// tick. The main instance uses GAP_MS=1; a second instance uses GAP_MS=0.
// -----------------------------------------------------------------------------
module tb_tone_scheduler;

    localparam int CF = 10_000;
    localparam int W  = 32;
    localparam int DW = 16;

    logic          clk;
    logic          reset;
    logic          req0_valid, req1_valid, abort;
    logic [W-1:0]  req0_freq, req1_freq;
    logic [DW-1:0] req0_dur_ms, req1_dur_ms;
    logic          req0_ready, req1_ready;
    logic          div_enable, busy, active_src, done, done_src;
    logic [W-1:0]  div_freq_hertz;

    logic          n_req0_valid, n_req1_valid, n_abort;
    logic [W-1:0]  n_req0_freq, n_req1_freq;
    logic [DW-1:0] n_req0_dur_ms, n_req1_dur_ms;
    logic          n_req0_ready, n_req1_ready;
    logic          n_div_enable, n_busy, n_active_src, n_done, n_done_src;
    logic [W-1:0]  n_div_freq_hertz;

    int n_vec = 0;
    int n_err = 0;

    tone_scheduler #(.CLOCK_FREQ(CF), .WIDTH(W), .DUR_WIDTH(DW), .GAP_MS(1)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_freq(req0_freq), .req0_dur_ms(req0_dur_ms),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_freq(req1_freq), .req1_dur_ms(req1_dur_ms),
        .req1_ready(req1_ready),
        .abort(abort), .div_enable(div_enable), .div_freq_hertz(div_freq_hertz),
        .busy(busy), .active_src(active_src), .done(done), .done_src(done_src)
    );

    tone_scheduler #(.CLOCK_FREQ(CF), .WIDTH(W), .DUR_WIDTH(DW), .GAP_MS(0)) dut_nogap (
        .clk(clk), .reset(reset),
        .req0_valid(n_req0_valid), .req0_freq(n_req0_freq), .req0_dur_ms(n_req0_dur_ms),
        .req0_ready(n_req0_ready),
        .req1_valid(n_req1_valid), .req1_freq(n_req1_freq), .req1_dur_ms(n_req1_dur_ms),
        .req1_ready(n_req1_ready),
        .abort(n_abort), .div_enable(n_div_enable), .div_freq_hertz(n_div_freq_hertz),
        .busy(n_busy), .active_src(n_active_src), .done(n_done), .done_src(n_done_src)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the cycle after acceptance; returns in the done cycle.
    task automatic run_tone(input string tag, input logic src, input int exp_hi, input int exp_gap);
        int hi;
        int gap;
        hi  = 0;
        gap = 0;
        while (div_enable && hi < 2000) begin
            step();
            hi++;
        end
        while (!done && gap < 2000) begin
            step();
            gap++;
        end
        chk({tag, "_hi_cycles"}, 64'(hi), 64'(exp_hi));
        chk({tag, "_quiet_cycles"}, 64'(gap), 64'(exp_gap));
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_done_src"}, done_src, src);
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        int hi;
        reset = 1'b1;
        req0_valid = 0; req1_valid = 0; abort = 0;
        req0_freq = '0; req1_freq = '0; req0_dur_ms = '0; req1_dur_ms = '0;
        n_req0_valid = 0; n_req1_valid = 0; n_abort = 0;
        n_req0_freq = '0; n_req1_freq = '0; n_req0_dur_ms = '0; n_req1_dur_ms = '0;

        // Reset values
        #1;
        chk("rst_en", div_enable, 1'b0);
        chk("rst_freq", div_freq_hertz, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_src", active_src, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_done_src", done_src, 1'b0);
        repeat (2) step();
        reset = 1'b0;

        // Contention: grants alternate 0,1,0,1, each accepted in the done cycle
        req0_valid = 1; req0_freq = 100; req0_dur_ms = 1;
        req1_valid = 1; req1_freq = 200; req1_dur_ms = 1;
        for (int i = 0; i < 4; i++) begin
            logic e;
            e = (i % 2 == 1);
            #1;
            chk("cont_ready_any", req0_ready | req1_ready, 1'b1);
            chk("cont_ready_both", req0_ready & req1_ready, 1'b0);
            chk("cont_grant", req1_ready, e);
            step();
            if (i == 3) begin
                req0_valid = 0;
                req1_valid = 0;
            end
            chk("cont_src", active_src, e);
            chk("cont_freq", div_freq_hertz, e ? 200 : 100);
            chk("cont_en", div_enable, 1'b1);
            run_tone("cont", e, 10, 10);
        end

        // Single tone: 440 Hz, 3 ms -> 30 high, 10 gap, done
        req0_valid = 1; req0_freq = 440; req0_dur_ms = 3;
        #1;
        chk("tone_ready", req0_ready, 1'b1);
        step();
        req0_valid = 0;
        chk("tone_en", div_enable, 1'b1);
        chk("tone_freq", div_freq_hertz, 440);
        chk("tone_busy", busy, 1'b1);
        chk("tone_src", active_src, 1'b0);
        run_tone("tone", 1'b0, 30, 10);
        chk("tone_freq_hold", div_freq_hertz, 440);
        step();
        chk("tone_done_pulse", done, 1'b0);

        // Rest: freq 0, 2 ms -> 30 silent cycles then done
        req0_valid = 1; req0_freq = 0; req0_dur_ms = 2;
        #1;
        chk("rest_ready", req0_ready, 1'b1);
        step();
        req0_valid = 0;
        chk("rest_busy", busy, 1'b1);
        run_tone("rest", 1'b0, 0, 30);

        // Zero duration: straight to a 10-cycle gap
        req0_valid = 1; req0_freq = 500; req0_dur_ms = 0;
        #1;
        step();
        req0_valid = 0;
        chk("zero_busy", busy, 1'b1);
        chk("zero_freq", div_freq_hertz, 500);
        run_tone("zero", 1'b0, 0, 10);

        // Abort in IDLE blocks acceptance
        req0_valid = 1; req0_freq = 123; req0_dur_ms = 1; abort = 1;
        #1;
        chk("abort_idle_ready", req0_ready, 1'b0);
        step();
        chk("abort_idle_busy", busy, 1'b0);
        abort = 0; req0_valid = 0;

        // Abort at PLAY cycle 12 with req1 pending
        req0_valid = 1; req0_freq = 300; req0_dur_ms = 3;
        #1;
        chk("abort_ready", req0_ready, 1'b1);
        step();
        req0_valid = 0;
        req0_freq = 999;
        repeat (11) step();
        chk("abort_en_pre", div_enable, 1'b1);
        chk("abort_freq_hold", div_freq_hertz, 300);
        abort = 1;
        req1_valid = 1; req1_freq = 600; req1_dur_ms = 1;
        #1;
        chk("abort_r1_blocked", req1_ready, 1'b0);
        step();
        abort = 0;
        #1;
        chk("abort_en", div_enable, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_no_done", done, 1'b0);
        chk("abort_r1_ready", req1_ready, 1'b1);
        step();
        req1_valid = 0;
        chk("abort_r1_src", active_src, 1'b1);
        chk("abort_r1_freq", div_freq_hertz, 600);
        run_tone("abort_r1", 1'b1, 10, 10);

        // GAP_MS=0 instance
        n_req0_valid = 1; n_req0_freq = 5; n_req0_dur_ms = 0;
        #1;
        chk("nogap_ready", n_req0_ready, 1'b1);
        step();
        n_req0_valid = 0;
        chk("nogap_zero_done", n_done, 1'b1);
        chk("nogap_zero_busy", n_busy, 1'b0);
        n_req0_freq = 7; n_req0_dur_ms = 2; n_req0_valid = 1;
        #1;
        step();
        n_req0_valid = 0;
        hi = 0;
        while (n_div_enable && hi < 2000) begin
            step();
            hi++;
        end
        chk("nogap_hi_cycles", 64'(hi), 64'(20));
        chk("nogap_done", n_done, 1'b1);

        // Asynchronous reset mid-PLAY (channel 0 was last granted)
        req0_valid = 1; req0_freq = 800; req0_dur_ms = 3;
        #1;
        step();
        req0_valid = 0;
        repeat (5) step();
        chk("arst_en_pre", div_enable, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_en", div_enable, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_freq", div_freq_hertz, '0);
        #2;
        reset = 1'b0;
        step();
        req0_valid = 1; req1_valid = 1; req0_dur_ms = 1; req1_dur_ms = 1;
        #1;
        chk("arst_grant0", req0_ready, 1'b1);
        chk("arst_grant1", req1_ready, 1'b0);
        req0_valid = 0; req1_valid = 0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
